// File: rtl/mem_bus_arbiter_pkg.sv
// Shared width define, FSM state encoding and master indices for the memory bus arbiter.
`ifndef MEM_BUS_ARBITER_DEFINES
`define MEM_BUS_ARBITER_DEFINES
`define WIDTH 32
`endif

package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: purely combinational, zero latency.
// No backpressure of its own; the caller only consults it while idle.
module rr_arbiter_2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    // On a tie the master that did not win last time goes first.
    if (&req) gnt_idx = ~last_grant;
    else      gnt_idx = req[1] ? M1 : M0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between two masters; write ack 2 cycles after grant, read ack 2+RD_LATENCY.
// Requests arriving outside IDLE are held off by the master's level request until the bus is free.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WIDTH      = `WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req_i,
  input  logic             m0_we_i,
  input  logic [WIDTH-1:0] m0_addr_i,
  input  logic [WIDTH-1:0] m0_wdata_i,
  output logic             m0_ack_o,
  output logic [WIDTH-1:0] m0_rdata_o,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  logic [WIDTH-1:0] m1_addr_i,
  input  logic [WIDTH-1:0] m1_wdata_i,
  output logic             m1_ack_o,
  output logic [WIDTH-1:0] m1_rdata_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic [WIDTH-1:0] memaddr_o,
  output logic [WIDTH-1:0] memwdata_o,
  input  logic [WIDTH-1:0] memrdata_i,
  output logic             busy_o
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             gnt_q, we_q, last_grant;
  logic [WIDTH-1:0] addr_q, wdata_q, m0_rdata_q, m1_rdata_q;
  logic             gnt_valid, gnt_idx;
  logic             rd_done;

  rr_arbiter_2 u_rr (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign rd_done = (state == WAIT) && (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_valid) state_nxt = ISSUE;
      ISSUE: state_nxt = we_q ? RESP : WAIT;
      WAIT:  if (rd_done) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= M0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= M1;
      cnt        <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          gnt_q      <= gnt_idx;
          we_q       <= (gnt_idx == M1) ? m1_we_i    : m0_we_i;
          addr_q     <= (gnt_idx == M1) ? m1_addr_i  : m0_addr_i;
          wdata_q    <= (gnt_idx == M1) ? m1_wdata_i : m0_wdata_i;
          last_grant <= gnt_idx;
        end
        ISSUE: if (!we_q) cnt <= CW'(RD_LATENCY);
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Read data is only captured for the granted master; the other keeps its last value.
          if (rd_done) begin
            if (gnt_q == M1) m1_rdata_q <= memrdata_i;
            else             m0_rdata_q <= memrdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    memread_o  = (state == ISSUE) && !we_q;
    memwrite_o = (state == ISSUE) &&  we_q;
    m0_ack_o   = (state == RESP) && (gnt_q == M0);
    m1_ack_o   = (state == RESP) && (gnt_q == M1);
    busy_o     = (state != IDLE);
  end

  assign memaddr_o  = addr_q;
  assign memwdata_o = wdata_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single MEMORY bus port between two masters: M0 (CORE data port) and M1 (auxiliary master, e.g. a DMA or VGA framebuffer copier).
- Arbitration is round-robin. The arbiter registers the winner's command, drives one-cycle memread/memwrite strobes, waits the memory read latency, then returns an ack (plus read data) to that master.
- Sits between the masters and MEMORY in the SoC top.

Parameters:
- WIDTH, `WIDTH (32), address and data width.
- RD_LATENCY, 1, cycles from the memread strobe cycle to the cycle where memrdata_i is valid. Must be at least 1; 0 is not supported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- m0_req_i  in  1  M0 transaction request (level)
- m0_we_i  in  1  M0 write(1)/read(0)
- m0_addr_i  in  WIDTH  M0 address
- m0_wdata_i  in  WIDTH  M0 write data
- m0_ack_o  out  1  M0 transaction complete (1-cycle pulse)
- m0_rdata_o  out  WIDTH  M0 read data, valid while m0_ack_o=1
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o: same as M0, for M1
- memread_o  out  1  memory read strobe
- memwrite_o  out  1  memory write strobe
- memaddr_o  out  WIDTH  memory address
- memwdata_o  out  WIDTH  memory write data
- memrdata_i  in  WIDTH  memory read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all outputs 0, rdata register 0.
  - last_grant=1, so M0 wins the first tie.
- Master rule:
  - Hold req and the command (we/addr/wdata) stable until ack.
  - On the clock edge where ack is sampled high, deassert req or present the next command.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requests: grant the master that is not last_grant.
  - On the grant edge, register gnt, we, addr and wdata; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - memaddr_o and memwdata_o driven from the registered command.
  - memwrite_o=we, memread_o=!we.
  - Next state: write goes to RESP; read goes to WAIT with the wait counter set to RD_LATENCY.
- WAIT:
  - Strobes are 0; memaddr_o holds its value.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, latch memrdata_i into the rdata register at the end of that cycle, then go to RESP.
  - The counter is $clog2(RD_LATENCY+1) bits wide.
- RESP (1 cycle):
  - ack of the granted master = 1; its rdata_o = rdata register. For writes, rdata_o holds its previous value.
  - The other master's ack = 0.
  - Next state: IDLE.
- Latency, counted from the IDLE edge that accepts req to the cycle with ack high:
  - write: 2 cycles.
  - read: 2 + RD_LATENCY cycles.
- Throughput: one transaction per (3 + RD_LATENCY) cycles for reads and 3 cycles for writes, including the IDLE cycle.
- Requests arriving outside IDLE are not sampled; they wait, with no loss.
- Fairness: with both masters continuously requesting, grants strictly alternate. A waiting master waits at most one transaction of the other master.
- memread_o and memwrite_o are never high together, and each is high for exactly one cycle per transaction.
- Reset mid-transaction:
  - Immediately return to IDLE, outputs to 0; no ack is issued.
  - A write whose ISSUE cycle has already completed has taken effect.
- Address is passed through unchanged; no address decode or width conversion.

Decomposition:
- Shared defines header supplies `WIDTH.
- A shared package holds the state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and the master-index constants M0=1'b0, M1=1'b1.
- One sub-module: rr_arbiter_2.
  - Combinational 2-way round-robin grant from req[1:0] and last_grant.
  - Outputs gnt_valid and gnt_idx.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high with no requests -> all outputs 0, busy_o=0, no strobes for 20 cycles.
- M0 write: addr=0x100, wdata=0xDEADBEEF -> memwrite_o=1 for exactly 1 cycle with those values; m0_ack_o pulses 2 cycles after acceptance; m1_ack_o stays 0.
- M1 read, RD_LATENCY=1, memory model returns 0x12345678 -> memread_o for 1 cycle; m1_ack_o 3 cycles after acceptance with m1_rdata_o=0x12345678.
- Simultaneous requests after reset, both held for 4 transactions -> grant order M0, M1, M0, M1; no overlapping strobes.
- RD_LATENCY=3 build, M0 read -> ack 5 cycles after acceptance; the rdata value is the one present in the 3rd cycle after the strobe, not the 1st or 2nd.
- rst asserted during WAIT of an M1 read -> outputs go to 0 asynchronously; no m1_ack_o; after release, a re-issued M1 read completes normally.
